// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each accepted request runs through IDLE -> EXEC -> RESP, so one operation completes every three cycles.
package alu_arbiter_pkg;
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MULT = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5
    } op_code_e;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic           req1_valid,
    output logic           req0_ready,
    output logic           req1_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    input  op_code_e       req0_op,
    input  op_code_e       req1_op,
    input  logic           req0_cin,
    input  logic           req1_cin,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output op_code_e       alu_op,
    output logic           alu_cin,
    input  logic [N-1:0]   alu_out,
    input  logic [2*N-1:0] alu_mult,
    input  logic           alu_z,
    input  logic           alu_nf,
    input  logic           alu_v,
    input  logic           alu_cout,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [N-1:0]   rsp_out,
    output logic [2*N-1:0] rsp_mult,
    output logic           rsp_z,
    output logic           rsp_nf,
    output logic           rsp_v,
    output logic           rsp_cout,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e state;
    logic   last;   // requester served most recently; also the id of the op in flight
    logic   grant;
    logic   idle;
    logic   accept;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid)
            grant = ~last;
    end

    assign idle       = (state == IDLE) && !rst;
    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);

    // The alu_* registers double as the operand latch, so they read zero/Add outside EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= OP_ADD;
            alu_cin  <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_out  <= '0;
            rsp_mult <= '0;
            rsp_z    <= 1'b0;
            rsp_nf   <= 1'b0;
            rsp_v    <= 1'b0;
            rsp_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a   <= grant ? req1_a   : req0_a;
                        alu_b   <= grant ? req1_b   : req0_b;
                        alu_op  <= grant ? req1_op  : req0_op;
                        alu_cin <= grant ? req1_cin : req0_cin;
                        last    <= grant;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_id   <= last;
                    rsp_out  <= alu_out;
                    rsp_mult <= alu_mult;
                    rsp_z    <= alu_z;
                    rsp_nf   <= alu_nf;
                    rsp_v    <= alu_v;
                    rsp_cout <= alu_cout;
                    alu_a    <= '0;
                    alu_b    <= '0;
                    alu_op   <= OP_ADD;
                    alu_cin  <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 4-bit ALU attached to the alu_* port.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    op_code_e req0_op, req1_op;
    logic req0_cin, req1_cin;
    logic [N-1:0] alu_a, alu_b, alu_out;
    op_code_e alu_op;
    logic alu_cin;
    logic [2*N-1:0] alu_mult;
    logic alu_z, alu_nf, alu_v, alu_cout;
    logic rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_out;
    logic [2*N-1:0] rsp_mult;
    logic rsp_z, rsp_nf, rsp_v, rsp_cout, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_cin(req0_cin), .req1_cin(req1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_mult(alu_mult),
        .alu_z(alu_z), .alu_nf(alu_nf), .alu_v(alu_v), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_mult(rsp_mult),
        .rsp_z(rsp_z), .rsp_nf(rsp_nf), .rsp_v(rsp_v), .rsp_cout(rsp_cout),
        .busy(busy)
    );

    // Reference ALU: carry/borrow in cout, signed overflow in v.
    always_comb begin
        logic [N:0] s;
        s        = '0;
        alu_mult = alu_a * alu_b;
        alu_out  = '0;
        alu_cout = 1'b0;
        alu_v    = 1'b0;
        case (alu_op)
            OP_ADD: begin
                s = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
                alu_out = s[N-1:0]; alu_cout = s[N];
                alu_v = (alu_a[N-1] == alu_b[N-1]) && (alu_out[N-1] != alu_a[N-1]);
            end
            OP_SUB: begin
                s = {1'b0, alu_a} - {1'b0, alu_b} - {{N{1'b0}}, alu_cin};
                alu_out = s[N-1:0]; alu_cout = s[N];
                alu_v = (alu_a[N-1] != alu_b[N-1]) && (alu_out[N-1] != alu_a[N-1]);
            end
            OP_MULT: begin
                alu_out = alu_mult[N-1:0]; alu_cout = |alu_mult[2*N-1:N];
            end
            OP_AND:  alu_out = alu_a & alu_b;
            OP_OR:   alu_out = alu_a | alu_b;
            default: alu_out = alu_a ^ alu_b;
        endcase
        alu_z  = (alu_out == '0);
        alu_nf = alu_out[N-1];
    end

    typedef struct {
        logic v0, v1;
        logic [N-1:0] a0, b0; op_code_e op0; logic c0;
        logic [N-1:0] a1, b1; op_code_e op1; logic c1;
        logic id;
        logic [N-1:0] out; logic [2*N-1:0] mult;
        logic z, nf, v, co;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic vld, input logic [N-1:0] a, input logic [N-1:0] b,
                            input op_code_e op, input logic cin);
        req0_valid = vld; req0_a = a; req0_b = b; req0_op = op; req0_cin = cin;
    endtask

    task automatic set_req1(input logic vld, input logic [N-1:0] a, input logic [N-1:0] b,
                            input op_code_e op, input logic cin);
        req1_valid = vld; req1_a = a; req1_b = b; req1_op = op; req1_cin = cin;
    endtask

    initial begin
        vec_t t;
        //            v0 v1  a0 b0  op0      c0  a1 b1  op1      c1  id out mult  z  nf v  co
        vecs[0] = '{1'b1, 1'b1, 4'd3, 4'd2, OP_SUB, 1'b0, 4'd3, 4'd2, OP_MULT, 1'b0, 1'b0, 4'd1, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'd3, 4'd2, OP_SUB, 1'b0, 4'd3, 4'd2, OP_MULT, 1'b0, 1'b1, 4'd6, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 4'd15, 4'd15, OP_ADD, 1'b1, 4'd1, 4'd1, OP_ADD, 1'b0, 1'b0, 4'd15, 8'd225, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 4'd3, 4'd2, OP_ADD, 1'b0, 4'd9, 4'd9, OP_SUB, 1'b1, 1'b0, 4'd5, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 4'd8, 4'd8, OP_SUB, 1'b0, 4'd15, 4'd1, OP_ADD, 1'b0, 1'b1, 4'd0, 8'd15, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 4'd1, 4'd1, OP_ADD, 1'b0, 4'd2, 4'd5, OP_SUB, 1'b0, 1'b1, 4'd13, 8'd10, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 4'd7, 4'd1, OP_ADD, 1'b1, 4'd4, 4'd4, OP_OR, 1'b0, 1'b0, 4'd9, 8'd7, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset with both requesters asserting: nothing may be granted.
        rst = 1'b1; rsp_ready = 1'b1;
        set_req0(1'b1, 4'd1, 4'd1, OP_ADD, 1'b0);
        set_req1(1'b1, 4'd2, 4'd2, OP_ADD, 1'b0);
        tick(); tick();
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_out", rsp_out, 0);
        chk("rst_rsp_mult", rsp_mult, 0);
        chk("rst_flags", {rsp_z, rsp_nf, rsp_v, rsp_cout}, 0);
        chk("rst_alu_op", alu_op, OP_ADD);
        req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            t = vecs[i];
            set_req0(t.v0, t.a0, t.b0, t.op0, t.c0);
            set_req1(t.v1, t.a1, t.b1, t.op1, t.c1);
            #1;
            chk($sformatf("v%0d_req0_ready", i), req0_ready, !t.id);
            chk($sformatf("v%0d_req1_ready", i), req1_ready, t.id);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_exec_busy", i), busy, 1);
            chk($sformatf("v%0d_exec_rsp_valid", i), rsp_valid, 0);
            chk($sformatf("v%0d_alu_a", i), alu_a, t.id ? t.a1 : t.a0);
            chk($sformatf("v%0d_alu_b", i), alu_b, t.id ? t.b1 : t.b0);
            chk($sformatf("v%0d_alu_op", i), alu_op, t.id ? t.op1 : t.op0);
            chk($sformatf("v%0d_alu_cin", i), alu_cin, t.id ? t.c1 : t.c0);
            tick();
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("v%0d_rsp_id", i), rsp_id, t.id);
            chk($sformatf("v%0d_rsp_out", i), rsp_out, t.out);
            chk($sformatf("v%0d_rsp_mult", i), rsp_mult, t.mult);
            chk($sformatf("v%0d_rsp_zn_v_c", i), {rsp_z, rsp_nf, rsp_v, rsp_cout}, {t.z, t.nf, t.v, t.co});
            chk($sformatf("v%0d_alu_idle", i), {alu_a, alu_b, alu_cin}, 0);
            chk($sformatf("v%0d_alu_op_idle", i), alu_op, OP_ADD);
            tick();
            chk($sformatf("v%0d_back_idle", i), busy, 0);
            chk($sformatf("v%0d_rsp_dropped", i), rsp_valid, 0);
        end

        // Backpressure: hold RESP for five cycles while requesters keep pushing.
        rsp_ready = 1'b0;
        set_req0(1'b1, 4'd3, 4'd2, OP_ADD, 1'b0);
        req1_valid = 1'b0;
        #1;
        chk("bp_req0_ready", req0_ready, 1);
        tick();
        tick();
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_a = 4'($urandom); req1_b = 4'($urandom); req1_op = OP_XOR;
            #1;
            chk($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("bp%0d_rsp_out", i), rsp_out, 5);
            chk($sformatf("bp%0d_rsp_id", i), rsp_id, 0);
            chk($sformatf("bp%0d_ready", i), {req0_ready, req1_ready}, 0);
            chk($sformatf("bp%0d_busy", i), busy, 1);
            tick();
        end
        rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("bp_release_busy", busy, 0);
        chk("bp_release_valid", rsp_valid, 0);

        // Cancel: request withdrawn before the edge leaves no trace.
        set_req1(1'b1, 4'd6, 4'd6, OP_ADD, 1'b0);
        #1;
        chk("cancel_ready_seen", req1_ready, 1);
        req1_valid = 1'b0;
        #1;
        chk("cancel_ready_gone", req1_ready, 0);
        tick();
        chk("cancel_busy", busy, 0);
        chk("cancel_rsp_valid", rsp_valid, 0);

        // Reset during EXEC discards the op and restores the tie pointer.
        set_req0(1'b1, 4'd15, 4'd15, OP_ADD, 1'b1);
        tick();
        req0_valid = 1'b0;
        chk("mid_exec_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_out", rsp_out, 0);
        chk("mid_rst_rsp_mult", rsp_mult, 0);
        chk("mid_rst_rsp_flags", {rsp_id, rsp_z, rsp_nf, rsp_v, rsp_cout}, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_no_rsp", rsp_valid, 0);
        set_req0(1'b1, 4'd1, 4'd1, OP_ADD, 1'b0);
        set_req1(1'b1, 4'd1, 4'd1, OP_ADD, 1'b0);
        #1;
        chk("post_rst_tie_req0", req0_ready, 1);
        chk("post_rst_tie_req1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
